// File: rtl/keypad_entry_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : keypad_entry_ctrl
//  Purpose  : Sequencing controller for a 4x4 matrix keypad. Scans the
//             columns, synchronizes the rows, debounces press and release,
//             decodes the key to a hex code and shifts it into a two-digit
//             history for the display path.
//  Ports    : clk        - system clock, all state on rising edge
//             reset      - synchronous, active-high reset
//             rows[3:0]  - keypad row lines, active-low, asynchronous
//             cols[3:0]  - keypad column drive, active-low one-hot
//             digit_new  - most recently accepted key code (right digit)
//             digit_old  - previously accepted key code (left digit)
//             key_valid  - one-cycle pulse on the cycle the digits update
//  Options  : KEYPAD_MULTIKEY_REJECT_EN - when defined, samples with two or
//             more rows low are rejected instead of resolved by priority.
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_entry_ctrl #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old,
    output logic       key_valid
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       sync1_q;
    logic [3:0]       rows_s_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       row_q, row_d;
    logic [3:0]       digit_new_q, digit_new_d;
    logic [3:0]       digit_old_q, digit_old_d;
    logic             key_valid_q, key_valid_d;

    logic [3:0]       low_rows;
    logic             any_low;
    logic [1:0]       low_row_idx;
    logic             row_low;
    logic             scan_hit;

    // Row-major key map: row 0 = 1 2 3 A, row 1 = 4 5 6 B,
    // row 2 = 7 8 9 C, row 3 = E 0 F D.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
            4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
            4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
            4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
        endcase
        return code;
    endfunction

    assign low_rows = ~rows_s_q;
    assign any_low  = |low_rows;
    assign row_low  = low_rows[row_q];

    // Lowest-index low row wins.
    always_comb begin
        low_row_idx = 2'd0;
        if (low_rows[0])      low_row_idx = 2'd0;
        else if (low_rows[1]) low_row_idx = 2'd1;
        else if (low_rows[2]) low_row_idx = 2'd2;
        else                  low_row_idx = 2'd3;
    end

`ifdef KEYPAD_MULTIKEY_REJECT_EN
    logic       multi_low;
    logic       other_low;
    logic [3:0] row_mask;
    // Clearing the lowest set bit leaves something only if 2+ rows are low.
    assign multi_low = |(low_rows & (low_rows - 4'd1));
    assign row_mask  = 4'b0001 << row_q;
    assign other_low = |(low_rows & ~row_mask);
    assign scan_hit  = any_low && !multi_low;
`else
    assign scan_hit  = any_low;
`endif

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        deb_d       = deb_q;
        col_d       = col_q;
        row_d       = row_q;
        digit_new_d = digit_new_q;
        digit_old_d = digit_old_q;
        key_valid_d = 1'b0;

        case (state_q)
            ST_SCAN: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (scan_hit) begin
                        // Column stays driven while the key is qualified.
                        row_d   = low_row_idx;
                        deb_d   = '0;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            ST_DEBOUNCE: begin
`ifdef KEYPAD_MULTIKEY_REJECT_EN
                if (other_low) begin
                    state_d = ST_SCAN;
                    col_d   = col_q + 2'd1;
                    div_d   = '0;
                end else
`endif
                if (row_low) begin
                    if (deb_q == DEB_LAST) begin
                        digit_old_d = digit_new_q;
                        digit_new_d = key_code(row_q, col_q);
                        key_valid_d = 1'b1;
                        state_d     = ST_HELD;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end else begin
                    state_d = ST_SCAN;
                    col_d   = col_q + 2'd1;
                    div_d   = '0;
                end
            end

            ST_HELD: begin
                if (!row_low) begin
                    deb_d   = '0;
                    state_d = ST_RELEASE;
                end
            end

            default: begin // ST_RELEASE
                if (row_low) begin
                    deb_d   = '0;
                    state_d = ST_HELD;
                end else if (deb_q == DEB_LAST) begin
                    state_d = ST_SCAN;
                    col_d   = col_q + 2'd1;
                    div_d   = '0;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_SCAN;
            sync1_q     <= 4'b1111;
            rows_s_q    <= 4'b1111;
            div_q       <= '0;
            deb_q       <= '0;
            col_q       <= 2'd0;
            row_q       <= 2'd0;
            digit_new_q <= 4'd0;
            digit_old_q <= 4'd0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= rows;
            rows_s_q    <= sync1_q;
            div_q       <= div_d;
            deb_q       <= deb_d;
            col_q       <= col_d;
            row_q       <= row_d;
            digit_new_q <= digit_new_d;
            digit_old_q <= digit_old_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign cols      = ~(4'b0001 << col_q);
    assign digit_new = digit_new_q;
    assign digit_old = digit_old_q;
    assign key_valid = key_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_entry_ctrl
//  Purpose  : Self-checking bench for keypad_entry_ctrl. A physical keypad
//             model pulls a row low only while a pressed key's column is
//             driven. Accepted presses are predicted as a queue of key codes
//             and matched against each key_valid pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_entry_ctrl;

    localparam int SCAN_DIV        = 4;
    localparam int DEBOUNCE_CYCLES = 8;
    localparam logic [3:0] KEYMAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] digit_new;
    logic [3:0] digit_old;
    logic       key_valid;

    logic [15:0] pressed = '0;   // bit r*4+c = key at row r, column c held down

    int         tests = 0;
    int         fails = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_new = 4'd0;
    logic [3:0] exp_old = 4'd0;
    logic [3:0] last_acc = 4'd0;

    keypad_entry_ctrl #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .digit_new (digit_new),
        .digit_old (digit_old),
        .key_valid (key_valid)
    );

    always #5 clk = ~clk;

    always_comb begin
        rows = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && (cols[c] === 1'b0)) rows[r] = 1'b0;
    end

    function automatic logic [3:0] col_oh(input int c);
        logic [3:0] v;
        v = 4'b1111;
        v[c] = 1'b0;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled on the falling edge. Every key_valid pulse
    // must match the oldest outstanding predicted press.
    task automatic tick();
        logic [3:0] code;
        @(posedge clk);
        @(negedge clk);
        if (key_valid !== 1'b0) begin
            chk("kv_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                code = exp_q.pop_front();
                chk("kv_digit_new", digit_new, code);
                chk("kv_digit_old", digit_old, last_acc);
                last_acc = code;
            end
        end
    endtask

    task automatic do_reset();
        exp_q.delete();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_new = 4'd0;
        exp_old = 4'd0;
        last_acc = 4'd0;
    endtask

    task automatic expect_key(input int r, input int c);
        exp_old = exp_new;
        exp_new = KEYMAP[r*4+c];
        exp_q.push_back(exp_new);
    endtask

    task automatic wait_cols(input string tag, input logic [3:0] target, input bit want_eq);
        int n = 0;
        while (((cols === target) != want_eq) && n < 40) begin
            tick();
            n++;
        end
        chk(tag, ((cols === target) == want_eq), 1);
    endtask

    task automatic end_phase(input string tag);
        chk({tag, "_pending"}, exp_q.size(), 0);
        chk({tag, "_new"}, digit_new, exp_new);
        chk({tag, "_old"}, digit_old, exp_old);
    endtask

    // Clean press of one key; long presses are predicted to be accepted once.
    task automatic press_release(input int r, input int c, input int hold, input int rel, input bit long_p);
        pressed[r*4+c] = 1'b1;
        if (long_p) expect_key(r, c);
        repeat (hold) tick();
        if (long_p) chk("hold_cols", cols, col_oh(c));
        pressed[r*4+c] = 1'b0;
        repeat (5) tick();
        if (long_p) chk("release_cols", cols, col_oh(c));
        repeat (rel - 5) tick();
        end_phase("press");
    endtask

    initial begin
        int r, c, hold, rel;
        bit lp;

        // Reset state and idle column scan.
        do_reset();
        chk("rst_cols", cols, 4'b1110);
        chk("rst_new", digit_new, 4'd0);
        chk("rst_old", digit_old, 4'd0);
        chk("rst_kv", key_valid, 1'b0);
        for (int n = 1; n <= 40; n++) begin
            tick();
            chk("idle_cols", cols, col_oh((n / SCAN_DIV) % 4));
        end
        end_phase("idle");

        // '6' then '0'.
        press_release(1, 2, 30, 20, 1'b1);
        press_release(3, 1, 40, 20, 1'b1);

        // Press bounce on row0/col0: never stable long enough.
        wait_cols("bnc_leave", 4'b1110, 1'b0);
        wait_cols("bnc_enter", 4'b1110, 1'b1);
        pressed[0] = 1'b1; repeat (3) tick();
        pressed[0] = 1'b0; repeat (1) tick();
        pressed[0] = 1'b1; repeat (3) tick();
        pressed[0] = 1'b0;
        wait_cols("bnc_resume", 4'b1110, 1'b0);
        chk("bnc_next_col", cols, 4'b1101);
        repeat (10) tick();
        end_phase("bounce");

        // Release bounce on 'A'.
        pressed[3] = 1'b1;
        expect_key(0, 3);
        repeat (40) tick();
        for (int k = 0; k < 2; k++) begin
            pressed[3] = 1'b0; repeat (3) tick();
            pressed[3] = 1'b1; repeat (2) tick();
        end
        chk("rbnc_cols", cols, 4'b0111);
        pressed[3] = 1'b0;
        repeat (25) tick();
        end_phase("rel_bounce");

        // Reset mid-debounce on '9' (row2/col2).
        wait_cols("rstd_leave", 4'b1011, 1'b0);
        wait_cols("rstd_enter", 4'b1011, 1'b1);
        pressed[10] = 1'b1;
        repeat (9) tick();
        do_reset();
        chk("rstd_cols", cols, 4'b1110);
        chk("rstd_new", digit_new, 4'd0);
        chk("rstd_old", digit_old, 4'd0);
        chk("rstd_kv", key_valid, 1'b0);
        repeat (8) tick();
        expect_key(2, 2);
        repeat (40) tick();
        pressed[10] = 1'b0;
        repeat (25) tick();
        end_phase("rst_debounce");

        // Rows 0 and 2 low together on column 0.
        wait_cols("multi_leave", 4'b1110, 1'b0);
        pressed[0] = 1'b1;
        pressed[8] = 1'b1;
`ifndef KEYPAD_MULTIKEY_REJECT_EN
        expect_key(0, 0);
`endif
        repeat (50) tick();
        pressed[0] = 1'b0;
        pressed[8] = 1'b0;
        repeat (25) tick();
        end_phase("multi");

        // Random clean presses and short taps.
        for (int i = 0; i < 12; i++) begin
            r    = $urandom_range(0, 3);
            c    = $urandom_range(0, 3);
            lp   = ($urandom_range(0, 2) != 0);
            hold = lp ? $urandom_range(40, 70) : $urandom_range(1, 5);
            rel  = $urandom_range(25, 35);
            press_release(r, c, hold, rel, lp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
